instr_sequencer: RTL
====================

// Module: instr_sequencer
// PURPOSE
//  Top-level fetch/execute controller for the CPUP core. Fetches 16-bit instructions over a req/ack memory port,
//  loads the instruction register feeding the execution module, restarts its microcode index, and waits for the
//  end-of-sequence microcode bit before the next fetch. Handles halt, fetch timeout fault and optional interrupt entry.
// PARAMETERS
//  IW        16       instruction width
//  AW        16       program-counter / fetch-address width
//  WAIT_MAX  15       max cycles mem_req may stay unacknowledged before FAULT (1..255)
//  IRQ_OP    16'hF000 instruction injected on interrupt entry
// PORTS
//  clock       in   1   system clock, rising-edge
//  reset_n     in   1   asynchronous, active-low reset
//  pc          in   AW  current program counter (register file P)
//  mem_req     out  1   fetch request, held until mem_ack or timeout
//  mem_addr    out  AW  fetch address, = pc captured on FETCH entry, stable while mem_req=1
//  mem_ack     in   1   fetch data valid this cycle
//  mem_rdata   in   IW  fetched instruction
//  instruction out  IW  instruction register
//  ir_valid    out  1   instruction register holds an executing instruction
//  mc_restart  out  1   one-cycle pulse: clear execution-module microcode index
//  mc_done     in   1   end-of-sequence microcode bit (microcode[22])
//  pc_inc      out  1   one-cycle pulse: increment P
//  halt        in   1   halt request (level)
//  halted      out  1   core halted
//  fault       out  1   fetch timeout, sticky until reset
//  irq_req     in   1   interrupt request (level)
//  irq_ack     out  1   one-cycle interrupt-taken pulse
// BEHAVIOUR
//  - All outputs registered. Reset: state IDLE; instruction=0, mem_addr=0, all 1-bit outputs 0, timeout count 0.
//  - States: IDLE, FETCH, EXEC, HALTED, FAULT, IRQ.
//  - IDLE: -> HALTED if halt, else FETCH (mem_addr<=pc, mem_req<=1). One cycle.
//  - FETCH: mem_req=1. Edge with mem_ack=1: instruction<=mem_rdata, ir_valid<=1, pc_inc and mc_restart pulse
//    next cycle, mem_req<=0, -> EXEC. Min fetch latency 1 cycle (ack in first request cycle).
//  - Timeout: count unacked request cycles; on WAIT_MAX-th without ack -> FAULT, mem_req<=0. Ack on that same
//    cycle wins (normal fetch, no fault). Count clears on every FETCH entry.
//  - EXEC: wait for mc_done=1 (ignored on the mc_restart cycle). On mc_done: ir_valid<=0; priority
//    halt -> HALTED; irq pending (IRQ build) -> IRQ; else -> FETCH with mem_addr<=pc.
//  - HALTED: halted=1. halt=0 -> FETCH (halted<=0). irq_req does not wake the core.
//  - FAULT: fault=1, all requests 0; exits only via reset_n.
//  - Ignored: mem_ack outside FETCH; mc_done outside EXEC; halt during FETCH (taken at next mc_done).
//  - reset_n asserted mid-fetch: mem_req drops asynchronously, in-flight ack discarded.
// CONFIGURATION
//  Macro INSTR_SEQ_IRQ_EN.
//  - Defined: at mc_done with halt=0, irq_req=1 -> IRQ: instruction<=IRQ_OP, ir_valid<=1, irq_ack and mc_restart
//    pulse, NO pc_inc (P preserved for the handler), -> EXEC. No nesting: irq_req ignored while instruction==IRQ_OP.
//  - Undefined: IRQ state not compiled; irq_req ignored; irq_ack tied 0. Ports remain for pin compatibility.
// STRUCTURE
//  - Package cpup_pkg: seq_state_t enum, default IRQ_OP constant, mc_done bit index (22).
//  - One sub-module: fetch_timeout_counter (clear, enable, WAIT_MAX compare, expired flag).
//  - FSM, IR and pulse generation in instr_sequencer.
// TESTING
//  1 Reset then pc=16'h0010, ack after 2 cycles, rdata=16'h1234 -> mem_addr=16'h0010, instruction=16'h1234,
//    ir_valid=1, pc_inc and mc_restart exactly one cycle each.
//  2 Ack in first request cycle -> EXEC next cycle; mc_done 3 cycles later -> new FETCH, mem_req=1, ir_valid=0.
//  3 WAIT_MAX=4, never ack -> fault=1 and mem_req=0 after 4 request cycles; repeat with ack on cycle 4 -> no fault.
//  4 halt=1 during FETCH -> fetch completes, executes, HALTED at mc_done; halt=0 -> next fetch from current pc.
//  5 IRQ build: irq_req=1 at mc_done -> instruction=16'hF000, irq_ack pulse, no pc_inc; non-IRQ build -> normal fetch.
//  6 Assert reset_n low while mem_req=1 and ack arrives -> outputs at reset values, instruction unchanged from 0.

Source files
------------

// File: rtl/cpup_pkg.sv
// Shared types and constants for the CPUP fetch/execute sequencer.
// INSTR_SEQ_IRQ_EN adds the IRQ state to the sequencer state set.
package cpup_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_HALTED,
        S_FAULT
`ifdef INSTR_SEQ_IRQ_EN
        ,
        S_IRQ
`endif
    } seq_state_t;

    localparam logic [15:0] IRQ_OP_DEF  = 16'hF000;
    localparam int          MC_DONE_BIT = 22;

endpackage

// File: rtl/fetch_timeout_counter.sv
// Counts unacknowledged fetch-request cycles; expired flags the
// WAIT_MAX-th such cycle so the sequencer can fault on the same edge.
module fetch_timeout_counter #(
    parameter int WAIT_MAX = 15
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [7:0] LAST = 8'(WAIT_MAX - 1);

    logic [7:0] count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= 8'd0;
        end else if (clear) begin
            count <= 8'd0;
        end else if (enable) begin
            count <= count + 8'd1;
        end
    end

    assign expired = enable && (count == LAST);

endmodule

// File: rtl/instr_sequencer.sv
// CPUP fetch/execute controller: fetch, IR load, microcode restart.
// Define INSTR_SEQ_IRQ_EN to build in interrupt entry.
module instr_sequencer
    import cpup_pkg::*;
#(
    parameter int            IW       = 16,
    parameter int            AW       = 16,
    parameter int            WAIT_MAX = 15,
    parameter logic [IW-1:0] IRQ_OP   = IRQ_OP_DEF
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic [AW-1:0] pc,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [IW-1:0] mem_rdata,
    output logic [IW-1:0] instruction,
    output logic          ir_valid,
    output logic          mc_restart,
    input  logic          mc_done,
    output logic          pc_inc,
    input  logic          halt,
    output logic          halted,
    output logic          fault,
    input  logic          irq_req,
    output logic          irq_ack
);

    seq_state_t    state, state_n;
    logic [IW-1:0] instruction_n;
    logic [AW-1:0] mem_addr_n;
    logic          mem_req_n, ir_valid_n;
    logic          mc_restart_n, pc_inc_n;
    logic          halted_n, fault_n, irq_ack_n;
    logic          start_fetch, tmo_clear;
    logic          tmo_enable, tmo_expired;

`ifdef INSTR_SEQ_IRQ_EN
    logic irq_take;
    // The handler's own opcode blocks re-entry (no nesting).
    assign irq_take = irq_req && (instruction != IRQ_OP);
`else
    logic unused_irq;
    assign unused_irq = irq_req | (^IRQ_OP);
`endif

    assign tmo_enable = (state == S_FETCH) && !mem_ack;

    fetch_timeout_counter #(
        .WAIT_MAX (WAIT_MAX)
    ) u_tmo (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (tmo_clear),
        .enable  (tmo_enable),
        .expired (tmo_expired)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            instruction <= '0;
            mem_addr    <= '0;
            mem_req     <= 1'b0;
            ir_valid    <= 1'b0;
            mc_restart  <= 1'b0;
            pc_inc      <= 1'b0;
            halted      <= 1'b0;
            fault       <= 1'b0;
            irq_ack     <= 1'b0;
        end else begin
            state       <= state_n;
            instruction <= instruction_n;
            mem_addr    <= mem_addr_n;
            mem_req     <= mem_req_n;
            ir_valid    <= ir_valid_n;
            mc_restart  <= mc_restart_n;
            pc_inc      <= pc_inc_n;
            halted      <= halted_n;
            fault       <= fault_n;
            irq_ack     <= irq_ack_n;
        end
    end

    always_comb begin
        state_n       = state;
        instruction_n = instruction;
        mem_addr_n    = mem_addr;
        mem_req_n     = mem_req;
        ir_valid_n    = ir_valid;
        mc_restart_n  = 1'b0;
        pc_inc_n      = 1'b0;
        halted_n      = halted;
        fault_n       = fault;
        irq_ack_n     = 1'b0;
        start_fetch   = 1'b0;
        tmo_clear     = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (halt) begin
                    state_n  = S_HALTED;
                    halted_n = 1'b1;
                end else begin
                    start_fetch = 1'b1;
                end
            end
            S_FETCH: begin
                // Ack on the expiring cycle still completes the fetch.
                if (mem_ack) begin
                    instruction_n = mem_rdata;
                    ir_valid_n    = 1'b1;
                    pc_inc_n      = 1'b1;
                    mc_restart_n  = 1'b1;
                    mem_req_n     = 1'b0;
                    state_n       = S_EXEC;
                end else if (tmo_expired) begin
                    mem_req_n = 1'b0;
                    fault_n   = 1'b1;
                    state_n   = S_FAULT;
                end
            end
            S_EXEC: begin
                // mc_done is stale while the index is being cleared.
                if (mc_done && !mc_restart) begin
                    ir_valid_n = 1'b0;
                    if (halt) begin
                        state_n  = S_HALTED;
                        halted_n = 1'b1;
                    end
`ifdef INSTR_SEQ_IRQ_EN
                    else if (irq_take) begin
                        state_n = S_IRQ;
                    end
`endif
                    else begin
                        start_fetch = 1'b1;
                    end
                end
            end
            S_HALTED: begin
                if (!halt) begin
                    halted_n    = 1'b0;
                    start_fetch = 1'b1;
                end
            end
            S_FAULT: begin
                state_n = S_FAULT;
            end
`ifdef INSTR_SEQ_IRQ_EN
            S_IRQ: begin
                instruction_n = IRQ_OP;
                ir_valid_n    = 1'b1;
                irq_ack_n     = 1'b1;
                mc_restart_n  = 1'b1;
                state_n       = S_EXEC;
            end
`endif
            default: begin
                state_n = S_IDLE;
            end
        endcase

        if (start_fetch) begin
            state_n    = S_FETCH;
            mem_addr_n = pc;
            mem_req_n  = 1'b1;
            tmo_clear  = 1'b1;
        end
    end

endmodule
